// File: rtl/amba_ahb_master_if.sv
// Command, response and AHB bus signals of amba_ahb_master, grouped with
// master/slave views.
interface amba_ahb_master_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic            cmd_write;
    logic [AW-1:0]   cmd_addr;
    logic [2:0]      cmd_size;
    logic            cmd_burst;
    logic [4*DW-1:0] cmd_wdata;

    logic            rdata_valid;
    logic [DW-1:0]   rdata;
    logic            rdata_last;
    logic            done;
    logic            err;

    logic [AW-1:0]   haddr;
    logic [1:0]      htrans;
    logic            hwrite;
    logic [2:0]      hsize;
    logic [2:0]      hburst;
    logic [3:0]      hprot;
    logic [DW-1:0]   hwdata;
    logic [DW-1:0]   hrdata;
    logic            hready;
    logic            hresp;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_burst, cmd_wdata,
               hrdata, hready, hresp,
        output cmd_ready, rdata_valid, rdata, rdata_last, done, err,
               haddr, htrans, hwrite, hsize, hburst, hprot, hwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_burst, cmd_wdata,
               hrdata, hready, hresp,
        input  cmd_ready, rdata_valid, rdata, rdata_last, done, err,
               haddr, htrans, hwrite, hsize, hburst, hprot, hwdata
    );
endinterface

// File: rtl/amba_ahb_master.sv
// AHB master issuing SINGLE / INCR4 commands with pipelined address/data phases.
// Optional AMBA_AHB_MASTER_ERR_CNT_EN adds a saturating err_cnt output.
module amba_ahb_master #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic hclk,
    input  logic hreset,
    amba_ahb_master_if.master bus
`ifdef AMBA_AHB_MASTER_ERR_CNT_EN
    ,
    output logic [7:0] err_cnt
`endif
);
    typedef enum logic [2:0] {IDLE, ADDR, BURST, LAST, ERR1, ERR2} state_t;

    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_NONSEQ = 2'b10;
    localparam logic [1:0] HT_SEQ    = 2'b11;

    state_t          state_q, state_d;
    logic [AW-1:0]   haddr_q, haddr_d;
    logic [1:0]      htrans_q, htrans_d;
    logic            hwrite_q, hwrite_d;
    logic [2:0]      hsize_q, hsize_d;
    logic [2:0]      hburst_q, hburst_d;
    logic [DW-1:0]   hwdata_q, hwdata_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            rvld_q, rvld_d, rlast_q, rlast_d;
    logic            done_q, done_d, err_q, err_d;
    logic            burst_q, burst_d;
    logic [4*DW-1:0] wdata_q, wdata_d;
    logic [1:0]      abeat_q, abeat_d, dbeat_q, dbeat_d;
    logic [1:0]      last_beat;
    logic            misalign, cross_1k, reject;
    logic [10:0]     end_off;

    // Reject misaligned / oversize commands and INCR4 spanning a 1 KB page.
    always_comb begin
        misalign = (bus.cmd_size > 3'd2) ||
                   (bus.cmd_size == 3'd1 && bus.cmd_addr[0]) ||
                   (bus.cmd_size == 3'd2 && bus.cmd_addr[1:0] != 2'b00);
        end_off  = {1'b0, bus.cmd_addr[9:0]} + (11'd4 << bus.cmd_size[1:0]);
        cross_1k = bus.cmd_burst && (end_off > 11'd1024);
        reject   = misalign || cross_1k;
    end

    assign last_beat = burst_q ? 2'd3 : 2'd0;

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q  <= IDLE;
            haddr_q  <= '0;
            htrans_q <= HT_IDLE;
            hwrite_q <= 1'b0;
            hsize_q  <= '0;
            hburst_q <= '0;
            hwdata_q <= '0;
            rdata_q  <= '0;
            rvld_q   <= 1'b0;
            rlast_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            burst_q  <= 1'b0;
            wdata_q  <= '0;
            abeat_q  <= '0;
            dbeat_q  <= '0;
        end else begin
            state_q  <= state_d;
            haddr_q  <= haddr_d;
            htrans_q <= htrans_d;
            hwrite_q <= hwrite_d;
            hsize_q  <= hsize_d;
            hburst_q <= hburst_d;
            hwdata_q <= hwdata_d;
            rdata_q  <= rdata_d;
            rvld_q   <= rvld_d;
            rlast_q  <= rlast_d;
            done_q   <= done_d;
            err_q    <= err_d;
            burst_q  <= burst_d;
            wdata_q  <= wdata_d;
            abeat_q  <= abeat_d;
            dbeat_q  <= dbeat_d;
        end
    end

    // ADDR: first address phase only; BURST: address n overlaps data n-1;
    // LAST: final data phase; ERR1/ERR2: two-cycle error response.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (bus.cmd_valid && !reject) state_d = ADDR;
            ADDR:  if (bus.hready) state_d = burst_q ? BURST : LAST;
            BURST: begin
                if (bus.hresp)       state_d = bus.hready ? ERR2 : ERR1;
                else if (bus.hready) state_d = (abeat_q == 2'd3) ? LAST : BURST;
            end
            LAST: begin
                if (bus.hresp)       state_d = bus.hready ? ERR2 : ERR1;
                else if (bus.hready) state_d = IDLE;
            end
            ERR1:  if (bus.hready) state_d = ERR2;
            ERR2:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        haddr_d  = haddr_q;
        htrans_d = htrans_q;
        hwrite_d = hwrite_q;
        hsize_d  = hsize_q;
        hburst_d = hburst_q;
        hwdata_d = hwdata_q;
        rdata_d  = rdata_q;
        rvld_d   = 1'b0;
        rlast_d  = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        burst_d  = burst_q;
        wdata_d  = wdata_q;
        abeat_d  = abeat_q;
        dbeat_d  = dbeat_q;
        case (state_q)
            IDLE: begin
                htrans_d = HT_IDLE;
                if (bus.cmd_valid) begin
                    if (reject) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        haddr_d  = bus.cmd_addr;
                        htrans_d = HT_NONSEQ;
                        hwrite_d = bus.cmd_write;
                        hsize_d  = bus.cmd_size;
                        hburst_d = bus.cmd_burst ? 3'b011 : 3'b000;
                        burst_d  = bus.cmd_burst;
                        wdata_d  = bus.cmd_wdata;
                        abeat_d  = 2'd0;
                    end
                end
            end
            ADDR, BURST, LAST: begin
                if (state_q != ADDR && bus.hresp) begin
                    // Cancel whatever address is still on the bus.
                    htrans_d = HT_IDLE;
                    if (bus.hready) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end
                end else if (bus.hready) begin
                    if (state_q != ADDR && !hwrite_q) begin
                        rdata_d = bus.hrdata;
                        rvld_d  = 1'b1;
                        rlast_d = (dbeat_q == last_beat);
                    end
                    if (state_q == LAST) done_d = 1'b1;
                    if (state_q != LAST) begin
                        hwdata_d = wdata_q[abeat_q*DW +: DW];
                        dbeat_d  = abeat_q;
                        if (abeat_q == last_beat) begin
                            htrans_d = HT_IDLE;
                        end else begin
                            haddr_d  = haddr_q + ({{(AW-1){1'b0}}, 1'b1} << hsize_q);
                            htrans_d = HT_SEQ;
                            abeat_d  = abeat_q + 2'd1;
                        end
                    end
                end
            end
            ERR1: begin
                htrans_d = HT_IDLE;
                if (bus.hready) begin
                    done_d = 1'b1;
                    err_d  = 1'b1;
                end
            end
            default: htrans_d = HT_IDLE;
        endcase
    end

`ifdef AMBA_AHB_MASTER_ERR_CNT_EN
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset)
            err_cnt <= '0;
        else if (done_d && err_d && err_cnt != 8'hFF)
            err_cnt <= err_cnt + 8'd1;
    end
`endif

    assign bus.cmd_ready   = (state_q == IDLE) && !hreset;
    assign bus.haddr       = haddr_q;
    assign bus.htrans      = htrans_q;
    assign bus.hwrite      = hwrite_q;
    assign bus.hsize       = hsize_q;
    assign bus.hburst      = hburst_q;
    assign bus.hprot       = 4'b0011;
    assign bus.hwdata      = hwdata_q;
    assign bus.rdata       = rdata_q;
    assign bus.rdata_valid = rvld_q;
    assign bus.rdata_last  = rlast_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_amba_ahb_master.sv
// Directed bench for amba_ahb_master: single/INCR4 transfers, errors,
// command rejection and mid-burst reset.
module tb_amba_ahb_master;
    logic hclk = 1'b0;
    logic hreset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    amba_ahb_master_if #(.AW(32), .DW(32)) bus ();

`ifdef AMBA_AHB_MASTER_ERR_CNT_EN
    logic [7:0] err_cnt;
    amba_ahb_master #(.AW(32), .DW(32)) dut (.hclk(hclk), .hreset(hreset), .bus(bus), .err_cnt(err_cnt));
`else
    amba_ahb_master #(.AW(32), .DW(32)) dut (.hclk(hclk), .hreset(hreset), .bus(bus));
`endif

    always #5 hclk = ~hclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic cmd(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                       input logic burst, input logic [127:0] wdata);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_size  = size;
        bus.cmd_burst = burst;
        bus.cmd_wdata = wdata;
    endtask

    task automatic slv(input logic rdy, input logic resp, input logic [31:0] rd);
        bus.hready = rdy;
        bus.hresp  = resp;
        bus.hrdata = rd;
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_size  = '0;
        bus.cmd_burst = 1'b0;
        bus.cmd_wdata = '0;
        slv(1'b1, 1'b0, 32'h0);

        // Reset state
        tick(); tick();
        chk("rst_htrans", 64'(bus.htrans), 64'd0);
        chk("rst_haddr", 64'(bus.haddr), 64'd0);
        chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        chk("rst_done_err", 64'({bus.done, bus.err, bus.rdata_valid, bus.rdata_last}), 64'd0);
        chk("rst_rdata", 64'(bus.rdata), 64'd0);
        chk("rst_hwdata", 64'({bus.hwdata, bus.hwrite, bus.hsize, bus.hburst}), 64'd0);
        hreset = 1'b0;
        #1;
        chk("rel_cmd_ready", 64'(bus.cmd_ready), 64'd1);

        // Single write
        tick();
        cmd(1'b1, 32'h10, 3'd2, 1'b0, 128'hDEADBEEF);
        chk("sw_ready_T", 64'(bus.cmd_ready), 64'd1);
        tick(); bus.cmd_valid = 1'b0;
        chk("sw_nonseq", 64'({bus.htrans, bus.haddr}), 64'({2'b10, 32'h10}));
        chk("sw_ctrl", 64'({bus.hwrite, bus.hsize, bus.hburst, bus.hprot}), 64'({1'b1, 3'd2, 3'd0, 4'b0011}));
        chk("sw_busy", 64'(bus.cmd_ready), 64'd0);
        tick();
        chk("sw_data", 64'({bus.htrans, bus.hwdata}), 64'({2'b00, 32'hDEADBEEF}));
        chk("sw_nodone_T2", 64'(bus.done), 64'd0);
        tick();
        chk("sw_done", 64'({bus.done, bus.err, bus.rdata_valid}), 64'({1'b1, 1'b0, 1'b0}));
        chk("sw_ready_T3", 64'(bus.cmd_ready), 64'd1);

        // INCR4 read, wait state on the second beat's data phase
        tick();
        cmd(1'b0, 32'h100, 3'd2, 1'b1, 128'h0);
        tick(); bus.cmd_valid = 1'b0;
        chk("rd_a0", 64'({bus.htrans, bus.haddr, bus.hburst}), 64'({2'b10, 32'h100, 3'b011}));
        tick(); slv(1'b1, 1'b0, 32'hA0A0_0000);
        chk("rd_a1", 64'({bus.htrans, bus.haddr}), 64'({2'b11, 32'h104}));
        chk("rd_nv_T2", 64'(bus.rdata_valid), 64'd0);
        tick(); slv(1'b0, 1'b0, 32'hFFFF_FFFF);
        chk("rd_a2", 64'({bus.htrans, bus.haddr}), 64'({2'b11, 32'h108}));
        chk("rd_b0", 64'({bus.rdata_valid, bus.rdata_last, bus.rdata}), 64'({2'b10, 32'hA0A0_0000}));
        tick(); slv(1'b1, 1'b0, 32'hA1A1_1111);
        chk("rd_a2_hold", 64'({bus.htrans, bus.haddr}), 64'({2'b11, 32'h108}));
        chk("rd_wait_nv", 64'(bus.rdata_valid), 64'd0);
        tick(); slv(1'b1, 1'b0, 32'hA2A2_2222);
        chk("rd_a3", 64'({bus.htrans, bus.haddr}), 64'({2'b11, 32'h10C}));
        chk("rd_b1", 64'({bus.rdata_valid, bus.rdata_last, bus.rdata}), 64'({2'b10, 32'hA1A1_1111}));
        tick(); slv(1'b1, 1'b0, 32'hA3A3_3333);
        chk("rd_idle", 64'(bus.htrans), 64'd0);
        chk("rd_b2", 64'({bus.rdata_valid, bus.rdata_last, bus.rdata, bus.done}), 64'({2'b10, 32'hA2A2_2222, 1'b0}));
        tick();
        chk("rd_b3", 64'({bus.rdata_valid, bus.rdata_last, bus.rdata}), 64'({2'b11, 32'hA3A3_3333}));
        chk("rd_done", 64'({bus.done, bus.err}), 64'({1'b1, 1'b0}));

        // INCR4 write, ERROR on the second beat
        tick();
        cmd(1'b1, 32'h200, 3'd2, 1'b1, {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111});
        tick(); bus.cmd_valid = 1'b0;
        chk("we_a0", 64'({bus.htrans, bus.haddr}), 64'({2'b10, 32'h200}));
        tick();
        chk("we_a1", 64'({bus.htrans, bus.haddr, bus.hwdata}), 64'({2'b11, 32'h204, 32'h1111_1111}));
        tick(); slv(1'b0, 1'b1, 32'h0);
        chk("we_b1_data", 64'({bus.htrans, bus.hwdata}), 64'({2'b11, 32'h2222_2222}));
        tick(); slv(1'b1, 1'b1, 32'h0);
        chk("we_cancel", 64'({bus.htrans, bus.done}), 64'({2'b00, 1'b0}));
        tick(); slv(1'b1, 1'b0, 32'h0);
        chk("we_done_err", 64'({bus.done, bus.err, bus.htrans}), 64'({1'b1, 1'b1, 2'b00}));
`ifdef AMBA_AHB_MASTER_ERR_CNT_EN
        chk("we_err_cnt", 64'(err_cnt), 64'd1);
`endif
        tick();
        chk("we_after", 64'({bus.done, bus.htrans, bus.cmd_ready}), 64'({1'b0, 2'b00, 1'b1}));

        // Misaligned single
        cmd(1'b0, 32'h102, 3'd2, 1'b0, 128'h0);
        tick(); bus.cmd_valid = 1'b0;
        chk("mis_done", 64'({bus.done, bus.err, bus.htrans}), 64'({1'b1, 1'b1, 2'b00}));
        tick();
        chk("mis_quiet", 64'({bus.done, bus.htrans}), 64'd0);

        // INCR4 crossing 1 KB
        cmd(1'b0, 32'h3F8, 3'd2, 1'b1, 128'h0);
        tick(); bus.cmd_valid = 1'b0;
        chk("1k_done", 64'({bus.done, bus.err, bus.htrans}), 64'({1'b1, 1'b1, 2'b00}));
        tick();
        chk("1k_quiet", 64'({bus.done, bus.htrans}), 64'd0);
`ifdef AMBA_AHB_MASTER_ERR_CNT_EN
        chk("err_cnt3", 64'(err_cnt), 64'd3);
`endif

        // INCR4 ending exactly on the 1 KB boundary, reset on beat 3
        cmd(1'b0, 32'h3F0, 3'd2, 1'b1, 128'h0);
        tick(); bus.cmd_valid = 1'b0;
        chk("rr_a0", 64'({bus.htrans, bus.haddr, bus.done}), 64'({2'b10, 32'h3F0, 1'b0}));
        tick(); tick(); tick();
        chk("rr_a3", 64'({bus.htrans, bus.haddr}), 64'({2'b11, 32'h3FC}));
        hreset = 1'b1;
        #1;
        chk("rr_abort", 64'({bus.htrans, bus.haddr, bus.rdata_valid}), 64'd0);
        chk("rr_ready_lo", 64'(bus.cmd_ready), 64'd0);
        tick();
        chk("rr_no_done", 64'({bus.done, bus.err}), 64'd0);
`ifdef AMBA_AHB_MASTER_ERR_CNT_EN
        chk("rr_err_cnt", 64'(err_cnt), 64'd0);
`endif
        hreset = 1'b0;
        #1;
        chk("rr_ready_hi", 64'(bus.cmd_ready), 64'd1);
        cmd(1'b0, 32'h40, 3'd2, 1'b0, 128'h0);
        tick(); bus.cmd_valid = 1'b0;
        chk("rs_nonseq", 64'({bus.htrans, bus.haddr, bus.hwrite}), 64'({2'b10, 32'h40, 1'b0}));
        tick(); slv(1'b1, 1'b0, 32'h1234_5678);
        chk("rs_idle", 64'(bus.htrans), 64'd0);
        tick();
        chk("rs_data", 64'({bus.rdata_valid, bus.rdata_last, bus.rdata}), 64'({2'b11, 32'h1234_5678}));
        chk("rs_done", 64'({bus.done, bus.err}), 64'({1'b1, 1'b0}));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/amba_ahb_master.md
AMBA_AHB_MASTER -- requirements
Module: amba_ahb_master

Interface
REQ-001 Parameters SHALL be: AW, default 32, address width; DW, default 32, data width (32 only).
REQ-002 Clock and reset SHALL be: one clock, hclk, input, 1 bit, rising-edge. Reset SHALL be hreset, input, 1 bit, asynchronous, active-high.
REQ-003 Command ports SHALL be:
- cmd_valid, in, 1, request present.
- cmd_ready, out, 1, master idle and accepting.
- cmd_write, in, 1, 1 = write.
- cmd_addr, in, AW, start address.
- cmd_size, in, 3, HSIZE code.
- cmd_burst, in, 1, 0 = SINGLE, 1 = INCR4.
- cmd_wdata, in, 4*DW, write beats; beat n is bits [n*DW +: DW].
REQ-004 Response ports SHALL be:
- rdata_valid, out, 1, read beat valid.
- rdata, out, DW, read beat.
- rdata_last, out, 1, final read beat.
- done, out, 1, one-cycle command-complete pulse.
- err, out, 1, qualifies done with failure.
REQ-005 AHB ports SHALL be:
- haddr, out, AW.
- htrans, out, 2.
- hwrite, out, 1.
- hsize, out, 3.
- hburst, out, 3.
- hprot, out, 4.
- hwdata, out, DW.
- hrdata, in, DW.
- hready, in, 1.
- hresp, in, 1.

Function
REQ-006 The FSM SHALL have exactly these states: IDLE, ADDR, BURST, LAST, ERR1, ERR2. All AHB outputs SHALL be registered.
REQ-007 cmd_ready SHALL be 1 only in IDLE. A command is accepted in cycle T when cmd_valid and cmd_ready are both 1.
REQ-008 At T+1 the master SHALL drive NONSEQ, haddr=cmd_addr, hsize, hwrite, and hburst (000 SINGLE, 011 INCR4); hprot SHALL be constant 4'b0011.
REQ-009 Address and control SHALL be held stable while hready=0.
REQ-010 The address phase completes on an hready=1 edge. The next beat's SEQ address (haddr + 2^hsize) SHALL then be presented in the same cycle as the current beat's data phase, giving pipelined overlap.
REQ-011 hwdata SHALL present beat n for the whole data phase of beat n, including wait states.
REQ-012 Read beats SHALL be captured when hready=1 in a data phase. rdata_valid SHALL pulse the following cycle; rdata_last SHALL be set for the final beat.
REQ-013 After the last address phase, htrans SHALL be IDLE (00). done SHALL pulse one cycle after the last data phase completes, and the FSM SHALL return to IDLE.
REQ-014 Back-to-back operation: the next command's NONSEQ SHALL appear no earlier than the cycle after done.
REQ-015 Error response: on hresp=1 with hready=0 in a data phase (ERR1), the master SHALL drive htrans=IDLE in the next cycle, cancelling all remaining beats.
REQ-016 On hresp=1 with hready=1 (ERR2), the master SHALL assert done=1, err=1 in the next cycle. No rdata_valid SHALL be produced for the errored beat.
REQ-017 If cmd_addr is not aligned to 2^cmd_size, or cmd_size > 2, the command SHALL be accepted with no bus transfer. done=1, err=1 SHALL assert at T+1.
REQ-018 An INCR4 whose four beats would cross a 1 KB boundary SHALL be rejected in the same way as REQ-017.

Reset
REQ-019 While hreset=1, outputs SHALL be:
- htrans = 00.
- haddr, hwdata, hsize, hburst, hwrite = 0.
- cmd_ready = 0.
- done, err, rdata_valid, rdata_last = 0.
- rdata = 0.
- FSM = IDLE.
REQ-020 hreset asserted mid-burst SHALL abort immediately with no done pulse. cmd_ready SHALL rise in the first cycle after hreset deasserts.

Configuration
REQ-021 Macro AMBA_AHB_MASTER_ERR_CNT_EN: when defined, the block SHALL add output err_cnt[7:0]. err_cnt SHALL increment on every done with err=1, saturate at 255, and reset to 0.
REQ-022 When AMBA_AHB_MASTER_ERR_CNT_EN is undefined, the err_cnt port and its logic SHALL be absent; all other behaviour is unchanged.

Verification
REQ-023 Single write, addr 0x10, size 2, wdata 0xDEADBEEF, hready=1 -> NONSEQ at T+1, hwdata=0xDEADBEEF at T+2, done at T+3, err=0.
REQ-024 INCR4 read from 0x100, size 2, one wait state on beat 2 -> haddr sequence 0x100, 0x104, 0x108, 0x10C (NONSEQ, then SEQ x3); four rdata_valid pulses; rdata_last on the 4th; done, err=0.
REQ-025 INCR4 write with slave ERROR on beat 2 -> htrans=IDLE the cycle after ERR1; no beats 3-4 issued; done=1, err=1; err_cnt=1 when macro defined.
REQ-026 Misaligned command, addr 0x102, size 2 -> no NONSEQ on the bus; done=1, err=1 at T+1.
REQ-027 INCR4 at 0x3F8, size 2 (crosses 1 KB) -> rejected with done=1, err=1 and no bus activity.
REQ-028 hreset pulsed during beat 3 of an INCR4 read -> htrans=00 immediately, no done; a new single read afterwards completes normally.
